// File: rtl/alu_flag_stack.sv
// Processor status register fed by the ALU flags, with a small LIFO save stack
// for nested interrupts and evaluation of the 16 branch condition codes.
module alu_flag_stack #(
    parameter int DEPTH = 4
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic [3:0] Flags,
    input  logic       FlagsWe,
    input  logic       Push,
    input  logic       Pop,
    input  logic       ClearErr,
    input  logic [3:0] Cond,
    output logic [3:0] StatusFlags,
    output logic       CondTrue,
    output logic [2:0] Depth,
    output logic       StackErr
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    logic [3:0] stack_r [DEPTH];
    logic [3:0] status_r;
    logic [2:0] depth_r;
    logic       err_r;

    state_t     state_s;
    logic [3:0] status_s;
    logic [2:0] depth_s;
    logic       err_s;
    logic       err_new_s;
    logic       wr_en_s;
    logic [3:0] top_s;
    logic       cond_s;

    // Stack state decoded from the occupancy counter
    always_comb begin
        state_s = ST_PARTIAL;
        if (depth_r == 3'd0) begin
            state_s = ST_EMPTY;
        end else if (depth_r == 3'(DEPTH)) begin
            state_s = ST_FULL;
        end else begin
            state_s = ST_PARTIAL;
        end
    end

    // Top-of-stack read mux
    always_comb begin
        top_s = 4'b0000;
        for (int i = 0; i < DEPTH; i++) begin
            if (depth_r == 3'(i + 1)) begin
                top_s = stack_r[i];
            end else begin
                top_s = top_s;
            end
        end
    end

    // Next-state: illegal push+pop first, then pop, then push, then plain capture
    always_comb begin
        status_s  = status_r;
        depth_s   = depth_r;
        err_new_s = 1'b0;
        wr_en_s   = 1'b0;
        if (Push && Pop) begin
            err_new_s = 1'b1;
        end else if (Pop) begin
            if (state_s != ST_EMPTY) begin
                status_s = top_s;
                depth_s  = depth_r - 3'd1;
            end else begin
                err_new_s = 1'b1;
                if (FlagsWe) begin
                    status_s = Flags;
                end else begin
                    status_s = status_r;
                end
            end
        end else if (Push) begin
            if (state_s != ST_FULL) begin
                wr_en_s = 1'b1;
                depth_s = depth_r + 3'd1;
            end else begin
                err_new_s = 1'b1;
            end
            if (FlagsWe) begin
                status_s = Flags;
            end else begin
                status_s = status_r;
            end
        end else if (FlagsWe) begin
            status_s = Flags;
        end else begin
            status_s = status_r;
        end
        // A fresh error outranks a same-cycle clear
        if (err_new_s) begin
            err_s = 1'b1;
        end else if (ClearErr) begin
            err_s = 1'b0;
        end else begin
            err_s = err_r;
        end
    end

    // Status, depth and sticky error registers
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            status_r <= 4'b0000;
            depth_r  <= 3'd0;
            err_r    <= 1'b0;
        end else begin
            status_r <= status_s;
            depth_r  <= depth_s;
            err_r    <= err_s;
        end
    end

    // Stack slots; a push writes the pre-update status at index Depth
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack_r[i] <= 4'b0000;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en_s && (depth_r == 3'(i))) begin
                    stack_r[i] <= status_r;
                end
            end
        end
    end

    // Branch condition evaluation; status bits are N,Z,C,V from MSB down
    always_comb begin
        cond_s = 1'b0;
        case (Cond)
            4'd0:    cond_s = 1'b1;
            4'd1:    cond_s = 1'b0;
            4'd2:    cond_s = status_r[2];
            4'd3:    cond_s = !status_r[2];
            4'd4:    cond_s = status_r[1];
            4'd5:    cond_s = !status_r[1];
            4'd6:    cond_s = status_r[3];
            4'd7:    cond_s = !status_r[3];
            4'd8:    cond_s = status_r[0];
            4'd9:    cond_s = !status_r[0];
            4'd10:   cond_s = status_r[1] && !status_r[2];
            4'd11:   cond_s = !status_r[1] || status_r[2];
            4'd12:   cond_s = (status_r[3] == status_r[0]);
            4'd13:   cond_s = (status_r[3] != status_r[0]);
            4'd14:   cond_s = !status_r[2] && (status_r[3] == status_r[0]);
            4'd15:   cond_s = status_r[2] || (status_r[3] != status_r[0]);
            default: cond_s = 1'b0;
        endcase
    end

    assign StatusFlags = status_r;
    assign Depth       = depth_r;
    assign StackErr    = err_r;
    assign CondTrue    = cond_s;

endmodule

// File: doc/alu_flag_stack.md
# alu_flag_stack

Registered consumer of the ALU condition flags. It latches `Flags` from the ALU on request and presents them as the processor status. It also saves and restores them on a small LIFO stack for nested interrupt entry and return, and evaluates the 16 branch condition codes against the held flags. It sits between the ALU `Flags` output and the control unit's branch and interrupt logic.

## Interface
One clock; reset is asynchronous and active-low.

Parameters:
- `DEPTH`, default 4: number of save slots in the flag stack; legal range 1..7.

Ports:
- `Clock`  in  1  system clock; all state changes on the rising edge.
- `nReset`  in  1  asynchronous active-low reset.
- `Flags`  in  4  ALU flags: [3]=N, [2]=Z, [1]=C, [0]=V.
- `FlagsWe`  in  1  capture `Flags` into the status register.
- `Push`  in  1  interrupt entry: save the current status onto the stack.
- `Pop`  in  1  interrupt return: restore the status from the top of the stack.
- `ClearErr`  in  1  clear the sticky `StackErr`.
- `Cond`  in  4  condition code select.
- `StatusFlags`  out  4  registered status flags, same bit order as `Flags`.
- `CondTrue`  out  1  result of condition `Cond` applied to `StatusFlags`.
- `Depth`  out  3  number of occupied stack slots, 0..`DEPTH`.
- `StackErr`  out  1  sticky error flag: overflow, underflow, or `Push` and `Pop` together.

## Operation
- Reset (`nReset` low, takes effect immediately): `StatusFlags`=4'b0000, `Depth`=0, `StackErr`=0, all stack slots 0. `CondTrue` is then 1 for codes 0, 3, 5, 7, 9, 11, 12, 14 and 0 for the rest.
- Stack control state machine:
  - States: EMPTY (`Depth`=0), PARTIAL (0<`Depth`<`DEPTH`), FULL (`Depth`=`DEPTH`).
  - The state is derived from the depth counter.
- Each cycle, in priority order:
  1. `Push`&`Pop` both asserted: illegal. Stack, `Depth` and `StatusFlags` are unchanged; `StackErr` is set. `FlagsWe` is ignored.
  2. `Pop`:
     - Stack not empty: `StatusFlags` <= top slot; `Depth` decrements. `FlagsWe` is ignored (the restore wins).
     - Stack empty: `StatusFlags` is unchanged and `StackErr` is set. A simultaneous `FlagsWe` is still honoured.
  3. `Push`:
     - Stack not full: the slot at index `Depth` <= the current `StatusFlags` (the pre-update value); `Depth` increments. If `FlagsWe` is also high, `StatusFlags` <= `Flags` in the same cycle.
     - Stack full: the stack is unchanged and `StackErr` is set. `FlagsWe` is still honoured.
  4. `FlagsWe` alone: `StatusFlags` <= `Flags`.
- `ClearErr` clears `StackErr` unless a new error occurs in the same cycle; a new error has priority.
- Condition codes (`CondTrue`, combinational from `StatusFlags`):

  | `Cond` | Name | True when |
  |---|---|---|
  | 0 | AL | always |
  | 1 | NV | never |
  | 2 | EQ | Z |
  | 3 | NE | !Z |
  | 4 | CS | C |
  | 5 | CC | !C |
  | 6 | MI | N |
  | 7 | PL | !N |
  | 8 | VS | V |
  | 9 | VC | !V |
  | 10 | HI | C&!Z |
  | 11 | LS | !C\|Z |
  | 12 | GE | N==V |
  | 13 | LT | N!=V |
  | 14 | GT | !Z&(N==V) |
  | 15 | LE | Z\|(N!=V) |

## Timing
- `StatusFlags`, `Depth` and `StackErr` change only on the rising edge of `Clock`, except on reset.
- Capture latency is 1 cycle: with `FlagsWe` sampled high at edge k, `Flags` appears on `StatusFlags` after edge k.
- `CondTrue` is combinational from `StatusFlags` and `Cond`. There is no bypass from the `Flags` input, so a branch issued in the same cycle as `FlagsWe` sees the old flags.
- Push and pop each take 1 cycle. Back-to-back pushes, back-to-back pops and alternating push/pop are all supported every cycle.
- Reset asserted mid-sequence discards all stack contents; `Depth` returns to 0 at once.

## Test plan
- Reset, then `Flags`=4'b0110 with `FlagsWe` for 1 cycle -> `StatusFlags`=0110; `Cond`=2 (EQ) gives `CondTrue`=1; `Cond`=10 (HI) gives 0.
- Sweep all 16 `Cond` values against every one of the 16 `StatusFlags` values (256 checks) -> each `CondTrue` matches the condition-code definitions.
- `StatusFlags`=1000, then `Push` with `FlagsWe` and `Flags`=0001 -> `Depth`=1, `StatusFlags`=0001. Then `Pop` with `FlagsWe` and `Flags`=1111 -> `StatusFlags`=1000, `Depth`=0.
- With `DEPTH`=4: 4 pushes of distinct flag values -> FULL, `StackErr`=0. A 5th push -> `Depth` stays 4, `StackErr`=1. Then 4 pops return the values in reverse order. A 5th pop -> `StatusFlags` unchanged, `StackErr` stays 1.
- `Push`&`Pop` together at `Depth`=2 -> no change to the stack, `Depth` or `StatusFlags`, and `StackErr`=1. `ClearErr` alone on the next cycle -> `StackErr`=0. `ClearErr` together with a pop from EMPTY -> `StackErr` stays 1.
- Push 3 entries, then drop `nReset` between clock edges -> `Depth`=0, `StatusFlags`=0000, `StackErr`=0 immediately, without waiting for a clock edge.
